// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa.sv
// Single-bit combinational full-adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Handshake: start is accepted on any edge where the FSM is in IDLE or DONE; done is a one-cycle result-valid pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    fa u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    // The result fills from the top so that after WIDTH shifts bit 0 is the LSB.
    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    res_d   = res_next;
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = fa_cout;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        sum_d   = res_next;
                        cout_d  = fa_cout;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that sequences one combinational full-adder cell over WIDTH cycles to add two WIDTH-bit operands plus carry-in.
- Operands are captured on a start handshake and shifted LSB-first through the cell.
- The carry is held in a flop between bits.
- The block pulses done with a registered sum/carry result.
- Serves as the area-minimal adder for low-throughput arithmetic paths next to the full-adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
abort  input  1  synchronous cancel; effective only in RUN
a_in  input  WIDTH  operand A, captured when start is accepted
b_in  input  WIDTH  operand B, captured when start is accepted
cin_in  input  1  carry-in, captured when start is accepted
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum_out  output  WIDTH  registered sum; held until next completion
cout_out  output  1  registered carry-out; held until next completion

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum_out=0, cout_out=0, bit counter=0, carry flop=0, shift registers=0.
- FSM states:
  - IDLE: start=1 → latch a_in, b_in, cin_in into shift regA, shift regB and the carry flop; clear the counter; go to RUN.
  - RUN, each edge:
    - Full-adder cell inputs: regA[0], regB[0], carry flop.
    - Cell sum shifts into the MSB of the result shift register (right shift).
    - regA and regB shift right.
    - Carry flop ← cell cout.
    - Counter increments.
    - When the counter reaches WIDTH-1 on that edge → go to DONE.
    - On the same edge: sum_out ← the final result register contents including the current bit; cout_out ← cell cout.
  - DONE: done=1 for exactly one cycle, busy=0.
    - start=1 → immediate re-accept, going directly to RUN with new operands (back-to-back).
    - Otherwise → IDLE.
- Latency: start sampled at edge E0; busy=1 for cycles E0..E(WIDTH); done=1 in the cycle after edge E(WIDTH). This is WIDTH+1 edges from acceptance to the done pulse.
- start in RUN is ignored; no queueing.
- abort in RUN → IDLE on the next edge. No done pulse. sum_out/cout_out keep their previous values. Counter cleared.
- abort and start high together in RUN: abort wins, start ignored.
- abort outside RUN has no effect.
- Operand inputs may change freely after acceptance; only latched copies are used.
- Arithmetic: {cout_out, sum_out} == a + b + cin, computed modulo 2^(WIDTH+1). No truncation.
- rst_n low at any time (including mid-RUN) asynchronously forces all reset values. No done is emitted for the interrupted operation.
- Counter width is $clog2(WIDTH). The comparison is against WIDTH-1, so there is no wrap-around issue.

Decomposition:
- Package serial_add_pkg contains:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t
  - localparam DEFAULT_WIDTH = 8
- One sub-module: the existing combinational full-adder cell fa, port order (a, b, cin, cout, sum), instantiated once.
- No other hierarchy.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start → busy high 8 cycles; done pulses once, 9 edges after acceptance; sum_out=0x96, cout_out=0.
- a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout_out=1. Then a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, cout_out=1.
- Start held high through RUN with different operands at cycle 3 → result still from the first operands. In the DONE cycle, start with a=0x01, b=0x02, cin=0 → RUN entered with no IDLE cycle; next result 0x03.
- abort at RUN cycle 4 of a 0x10+0x20 op → IDLE next edge; done never pulses; sum_out/cout_out retain the prior result.
- rst_n low mid-RUN (cycle 5) → all outputs 0 immediately, without a clock. After release, a fresh 0x7F+0x01 add gives 0x80, cout 0.
- 256 random (a, b, cin) ops, back-to-back → immediate assertion at each done: {cout_out, sum_out} == a+b+cin. Report PASSED/FAILED counts; zero failures required.
